// File: rtl/pmp_csr_file.sv
// pmp_csr_file: machine-mode pmpcfg0-3 / pmpaddr0-15 register bank with lock, TOR-lock and WARL rules.
module pmp_csr_file (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_we,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_hit,
    output logic [31:0] pmpcfg0_data,
    output logic [31:0] pmpcfg1_data,
    output logic [31:0] pmpcfg2_data,
    output logic [31:0] pmpcfg3_data,
    output logic [31:0] pmpaddr0_data,
    output logic [31:0] pmpaddr1_data,
    output logic [31:0] pmpaddr2_data,
    output logic [31:0] pmpaddr3_data,
    output logic [31:0] pmpaddr4_data,
    output logic [31:0] pmpaddr5_data,
    output logic [31:0] pmpaddr6_data,
    output logic [31:0] pmpaddr7_data,
    output logic [31:0] pmpaddr8_data,
    output logic [31:0] pmpaddr9_data,
    output logic [31:0] pmpaddr10_data,
    output logic [31:0] pmpaddr11_data,
    output logic [31:0] pmpaddr12_data,
    output logic [31:0] pmpaddr13_data,
    output logic [31:0] pmpaddr14_data,
    output logic [31:0] pmpaddr15_data
);
    logic [31:0]  cfg [4];
    logic [31:0]  addr [16];
    logic [127:0] cfg_flat;
    logic [15:0]  lock, tor, addr_lock;
    logic         is_cfg, is_addr, commit;
    logic [31:0]  cur, cand, cfg_next;

    function automatic logic [7:0] warl(input logic [7:0] b);
        return {b[7], 2'b00, b[4:2], b[1] & b[0], b[0]};
    endfunction

    assign is_cfg    = csr_addr[11:2] == 10'h0E8;
    assign is_addr   = csr_addr[11:4] == 8'h3B;
    assign csr_hit   = is_cfg | is_addr;
    assign commit    = csr_we & csr_hit & (csr_op != 2'b00);
    assign cur       = is_cfg ? cfg[csr_addr[1:0]] : is_addr ? addr[csr_addr[3:0]] : 32'h0;
    assign csr_rdata = cur;
    assign cand      = csr_op == 2'b01 ? csr_wdata : csr_op == 2'b10 ? cur | csr_wdata : cur & ~csr_wdata;
    assign cfg_flat  = {cfg[3], cfg[2], cfg[1], cfg[0]};

    always_comb begin
        lock = '0;
        tor  = '0;
        for (int n = 0; n < 16; n++) begin
            lock[n] = cfg_flat[8*n+7];
            tor[n]  = cfg_flat[8*n+3 +: 2] == 2'b01;
        end
    end

    // an entry's address is also frozen when the next entry is a locked TOR top
    assign addr_lock = lock | {1'b0, lock[15:1] & tor[15:1]};

    always_comb begin
        cfg_next = cur;
        for (int k = 0; k < 4; k++)
            if (!cur[8*k+7]) cfg_next[8*k +: 8] = warl(cand[8*k +: 8]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < 4; j++) cfg[j] <= '0;
            for (int n = 0; n < 16; n++) addr[n] <= '0;
        end else if (commit) begin
            if (is_cfg) cfg[csr_addr[1:0]] <= cfg_next;
            else if (!addr_lock[csr_addr[3:0]]) addr[csr_addr[3:0]] <= cand;
        end
    end

    assign pmpcfg0_data   = cfg[0];
    assign pmpcfg1_data   = cfg[1];
    assign pmpcfg2_data   = cfg[2];
    assign pmpcfg3_data   = cfg[3];
    assign pmpaddr0_data  = addr[0];
    assign pmpaddr1_data  = addr[1];
    assign pmpaddr2_data  = addr[2];
    assign pmpaddr3_data  = addr[3];
    assign pmpaddr4_data  = addr[4];
    assign pmpaddr5_data  = addr[5];
    assign pmpaddr6_data  = addr[6];
    assign pmpaddr7_data  = addr[7];
    assign pmpaddr8_data  = addr[8];
    assign pmpaddr9_data  = addr[9];
    assign pmpaddr10_data = addr[10];
    assign pmpaddr11_data = addr[11];
    assign pmpaddr12_data = addr[12];
    assign pmpaddr13_data = addr[13];
    assign pmpaddr14_data = addr[14];
    assign pmpaddr15_data = addr[15];
endmodule

// File: tb/tb_pmp_csr_file.sv
// tb_pmp_csr_file: directed-vector bench for pmp_csr_file with hand-computed expectations.
module tb_pmp_csr_file;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csr_we = 1'b0;
    logic [1:0]  csr_op = 2'b00;
    logic [11:0] csr_addr = 12'h000;
    logic [31:0] csr_wdata = 32'h0;
    logic [31:0] csr_rdata;
    logic        csr_hit;
    logic [31:0] cfg0, cfg1, cfg2, cfg3;
    logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7, a8, a9, a10, a11, a12, a13, a14, a15;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pmp_csr_file dut (
        .clk(clk), .rst(rst), .csr_we(csr_we), .csr_op(csr_op), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_hit(csr_hit),
        .pmpcfg0_data(cfg0), .pmpcfg1_data(cfg1), .pmpcfg2_data(cfg2), .pmpcfg3_data(cfg3),
        .pmpaddr0_data(a0), .pmpaddr1_data(a1), .pmpaddr2_data(a2), .pmpaddr3_data(a3),
        .pmpaddr4_data(a4), .pmpaddr5_data(a5), .pmpaddr6_data(a6), .pmpaddr7_data(a7),
        .pmpaddr8_data(a8), .pmpaddr9_data(a9), .pmpaddr10_data(a10), .pmpaddr11_data(a11),
        .pmpaddr12_data(a12), .pmpaddr13_data(a13), .pmpaddr14_data(a14), .pmpaddr15_data(a15)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // all stimulus tasks start and end on a falling edge
    task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        csr_we = 1'b1; csr_op = op; csr_addr = a; csr_wdata = d;
        @(negedge clk);
        csr_we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp, input logic hit);
        csr_addr = a;
        #1;
        check({tag, "_rdata"}, csr_rdata, exp);
        check({tag, "_hit"}, {31'b0, csr_hit}, {31'b0, hit});
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 4; j++) rd($sformatf("rst_cfg%0d", j), 12'h3A0 + 12'(j), 32'h0, 1'b1);
        for (int n = 0; n < 16; n++) rd($sformatf("rst_addr%0d", n), 12'h3B0 + 12'(n), 32'h0, 1'b1);
        rd("miss_3a4", 12'h3A4, 32'h0, 1'b0);
        rd("miss_3c0", 12'h3C0, 32'h0, 1'b0);

        // WARL on cfg bytes; same-cycle read sees the pre-write value
        csr_we = 1'b1; csr_op = 2'b01; csr_addr = 12'h3A0; csr_wdata = 32'hFF621B03;
        #1 check("rd_before_write", csr_rdata, 32'h0);
        @(negedge clk);
        csr_we = 1'b0;
        check("warl_cfg0", cfg0, 32'h9F001B03);
        rd("warl_rd", 12'h3A0, 32'h9F001B03, 1'b1);

        do_reset();
        wr(2'b01, 12'h3A0, 32'h00000080);
        wr(2'b01, 12'h3B0, 32'h12345678);
        check("lock_addr0", a0, 32'h0);
        wr(2'b01, 12'h3A0, 32'h00000000);
        check("lock_sticky", cfg0, 32'h00000080);
        wr(2'b01, 12'h3A0, 32'h00000F00);
        check("lock_neighbour", cfg0, 32'h00000F80);
        wr(2'b01, 12'h3B1, 32'h00000005);
        check("addr1_free", a1, 32'h5);

        do_reset();
        wr(2'b10, 12'h3A0, 32'h00008800);
        check("tor_cfg", cfg0, 32'h00008800);
        wr(2'b01, 12'h3B0, 32'h00000100);
        check("tor_addr0", a0, 32'h0);
        wr(2'b01, 12'h3B1, 32'h00000007);
        check("tor_addr1_locked", a1, 32'h0);
        wr(2'b01, 12'h3B2, 32'h00000200);
        check("tor_addr2", a2, 32'h200);
        wr(2'b01, 12'h3BF, 32'hDEADBEEF);
        check("addr15", a15, 32'hDEADBEEF);

        wr(2'b01, 12'h3B5, 32'h000000F0);
        wr(2'b10, 12'h3B5, 32'h0000000F);
        check("set_addr5", a5, 32'hFF);
        wr(2'b11, 12'h3B5, 32'h0000003C);
        check("clr_addr5", a5, 32'hC3);
        wr(2'b00, 12'h3B5, 32'h00000000);
        check("noop_addr5", a5, 32'hC3);
        wr(2'b10, 12'h3A0, 32'h00007700);
        check("set_locked", cfg0, 32'h00008800);
        wr(2'b11, 12'h3A0, 32'h0000FF00);
        check("clr_locked", cfg0, 32'h00008800);
        wr(2'b10, 12'h3A0, 32'h00000002);
        check("set_w_only", cfg0, 32'h00008800);
        wr(2'b10, 12'h3A0, 32'h00000003);
        check("set_rw", cfg0, 32'h00008803);
        wr(2'b11, 12'h3A0, 32'h00000001);
        check("clr_r_drops_w", cfg0, 32'h00008800);
        wr(2'b01, 12'h3C0, 32'hFFFFFFFF);
        check("miss_write_cfg0", cfg0, 32'h00008800);
        check("miss_write_addr5", a5, 32'hC3);

        csr_we = 1'b1; csr_op = 2'b10; csr_addr = 12'h3B6; csr_wdata = 32'h1;
        @(negedge clk);
        csr_wdata = 32'h2;
        @(negedge clk);
        csr_we = 1'b0;
        check("b2b_addr6", a6, 32'h3);

        do_reset();
        wr(2'b01, 12'h3A0, 32'h00000080);
        wr(2'b01, 12'h3B5, 32'h00000055);
        check("pre_rst_cfg0", cfg0, 32'h80);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_cfg0", cfg0, 32'h0);
        check("async_addr5", a5, 32'h0);
        csr_addr = 12'h3A0;
        #1 check("async_rdata", csr_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        wr(2'b01, 12'h3B0, 32'h00000ABC);
        check("post_rst_addr0", a0, 32'hABC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
